down_timer_ctrl: RTL and testbench
==================================

// Module: down_timer_ctrl
// PURPOSE
//   Sequencer for the T-flip-flop down-counter datapath. Loads a start value,
//   runs the count down under a programmable prescaler, and supports pause,
//   abort and auto-reload. Signals terminal count with a one-cycle done pulse.
//   Sits between control/CSR logic and the counter, which it drives as a tick-enabled down counter.
// PARAMETERS
//   WIDTH   4   count width in bits
//   PRE_W   4   prescaler width; one tick every (prescale+1) clk cycles
// PORTS
//   clk        in   1      clock, all logic on rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin a count; honoured only in IDLE
//   pause      in   1      level: hold count while high (RUN<->HOLD)
//   abort      in   1      return to IDLE from any state
//   load_val   in   WIDTH  start/reload value, sampled at start
//   prescale   in   PRE_W  tick divider, sampled at start
//   reload_en  in   1      in DONE: 1=reload and rerun, 0=go IDLE (live)
//   count      out  WIDTH  current count value
//   running    out  1      state==RUN
//   paused     out  1      state==HOLD
//   done       out  1      state==DONE (exactly one cycle per terminal count)
//   state      out  2      IDLE=00 RUN=01 HOLD=10 DONE=11
// BEHAVIOUR
//   - Reset: state=IDLE, count=0, prescaler counter=0, latched regs=0,
//     running=paused=done=0. Reset mid-run discards all progress.
//   - All outputs registered or decoded from registered state; no comb paths in->out.
//   - Priority every cycle: rst > abort > pause > tick/start.
//   - IDLE: start=1 -> latch load_val (rld) and prescale (P); count<=load_val;
//     pcnt<=P; next state RUN, or DONE if load_val==0. Otherwise hold.
//   - RUN: pcnt==0 is a tick: pcnt<=P, count<=count-1; tick with count==1
//     -> count<=0, state DONE. No tick: pcnt<=pcnt-1.
//   - Latency: Nth decrement on the N*(P+1)th edge after the loading edge;
//     done high in the cycle after that edge.
//   - pause=1 in RUN -> HOLD; count and pcnt frozen. pause=0 in HOLD -> RUN,
//     prescaler resumes from frozen pcnt (no lost or extra ticks).
//   - DONE (count=0): reload_en=1 -> count<=rld, pcnt<=P, RUN (period
//     N*(P+1)+1 cycles); if rld==0, stay DONE with done high. reload_en=0 -> IDLE.
//     pause in DONE ignored.
//   - abort in RUN/HOLD/DONE: next edge state=IDLE, count=0, pcnt=0.
//   - start outside IDLE ignored; load_val/prescale changes mid-run ignored.
//   - count never underflows/wraps: decrement only from count>=1.
//   - start and abort together in IDLE: abort wins, stay IDLE.
// TESTING
//   1. Run load 7, rst high 2 cycles mid-count -> state=00, count=0, all flags 0.
//   2. P=0, load 5, start -> count 5,4,3,2,1,0 on consecutive cycles; done=1
//      one cycle with count=0; then IDLE, done=0.
//   3. P=2, load 3 -> count steps every 3 cycles; done after edge 9 post-load.
//   4. P=0, load 6, pause high 4 cycles at count=3 -> paused=1, count=3 held;
//      done 4 cycles later than test-2 timing.
//   5. P=0, load 2, reload_en=1 -> count 2,1,0,2,1,0...; done every 3 cycles.
//   6. load 0 start -> DONE next cycle, single done pulse; abort in RUN ->
//      IDLE, count=0 next edge; start while RUN -> no effect on count.

Source files
------------

// File: rtl/down_timer_ctrl.sv
// down_timer_ctrl: tick-prescaled down-count sequencer with pause, abort and auto-reload
module down_timer_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic             reload_en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             paused_o,
  output logic             done_o,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, rld_q, rld_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d, p_q, p_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      pcnt_q  <= '0;
      rld_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      rld_q   <= rld_d;
      p_q     <= p_d;
    end
  end
  // Leaving HOLD counts that edge like RUN, so a pause costs exactly its high cycles
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    rld_d   = rld_q;
    p_d     = p_q;
    if (abort_i) begin
      state_d = IDLE;
      count_d = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          rld_d   = load_val_i;
          p_d     = prescale_i;
          count_d = load_val_i;
          pcnt_d  = prescale_i;
          state_d = (load_val_i == '0) ? DONE : RUN;
        end
        RUN, HOLD: if (pause_i) state_d = HOLD;
          else if (pcnt_q == '0 && count_q != '0) begin
            pcnt_d  = p_q;
            count_d = count_q - 1'b1;
            state_d = (count_q == WIDTH'(1)) ? DONE : RUN;
          end else begin
            pcnt_d  = (pcnt_q == '0) ? '0 : pcnt_q - 1'b1;
            state_d = RUN;
          end
        default: if (!reload_en_i) state_d = IDLE;
          else if (rld_q != '0) begin
            count_d = rld_q;
            pcnt_d  = p_q;
            state_d = RUN;
          end
      endcase
    end
  end
  assign count_o   = count_q;
  assign state_o   = state_q;
  assign running_o = state_q == RUN;
  assign paused_o  = state_q == HOLD;
  assign done_o    = state_q == DONE;
endmodule

// File: tb/tb_down_timer_ctrl.sv
// tb_down_timer_ctrl: directed checks of the down-timer sequencer against hand-computed values
module tb_down_timer_ctrl;
  logic clk = 0, rst = 1, start = 0, pause = 0, abort = 0, reload_en = 0;
  logic [3:0] load_val = 0, prescale = 0, count;
  logic running, paused, done;
  logic [1:0] state;
  int n_cmp = 0, n_err = 0;
  down_timer_ctrl #(.WIDTH(4), .PRE_W(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .pause_i(pause), .abort_i(abort),
    .load_val_i(load_val), .prescale_i(prescale), .reload_en_i(reload_en),
    .count_o(count), .running_o(running), .paused_o(paused), .done_o(done), .state_o(state)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_flags"}, {running, paused, done}, 0);
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    chk_idle("reset");
    // 1: reset mid-count
    load_val = 7; prescale = 0; start = 1;
    tick();
    start = 0;
    chk("t1_load", count, 7);
    chk("t1_run", running, 1);
    tick();
    tick();
    chk("t1_mid", count, 5);
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk_idle("t1_rst");
    tick();
    chk_idle("t1_stay");
    // 2: P=0 load 5
    load_val = 5; start = 1;
    tick();
    start = 0;
    chk("t2_load", count, 5);
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk($sformatf("t2_cnt%0d", i), count, i);
      chk($sformatf("t2_done%0d", i), done, i == 0);
    end
    chk("t2_state_done", state, 3);
    tick();
    chk_idle("t2_idle");
    // 3: P=2 load 3, step every 3 edges
    load_val = 3; prescale = 2; start = 1;
    tick();
    start = 0;
    chk("t3_load", count, 3);
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("t3_e%0d", e), count, 3 - e / 3);
      chk($sformatf("t3_done_e%0d", e), done, e == 9);
    end
    tick();
    chk_idle("t3_idle");
    // 4: P=0 load 6, pause 4 cycles at count 3
    load_val = 6; prescale = 0; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    tick();
    chk("t4_pre", count, 3);
    pause = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_paused", paused, 1);
      chk("t4_hold", count, 3);
      chk("t4_state", state, 2);
    end
    pause = 0;
    tick();
    chk("t4_resume", count, 2);
    chk("t4_run", running, 1);
    tick();
    chk("t4_c1", count, 1);
    chk("t4_nodone", done, 0);
    tick();
    chk("t4_c0", count, 0);
    chk("t4_done", done, 1);
    pause = 1;
    tick();
    pause = 0;
    chk_idle("t4_idle");
    // 5: P=0 load 2 with auto-reload
    load_val = 2; reload_en = 1; start = 1;
    tick();
    start = 0;
    chk("t5_load", count, 2);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t5_c1", count, 1);
      tick();
      chk("t5_c0", count, 0);
      chk("t5_done", done, 1);
      tick();
      chk("t5_reload", count, 2);
      chk("t5_rundone", {running, done}, 2'b10);
    end
    tick();
    tick();
    chk("t5_last_done", done, 1);
    reload_en = 0;
    tick();
    chk_idle("t5_idle");
    // 6: load 0, start ignored while running, abort, start+abort
    load_val = 0; start = 1;
    tick();
    start = 0;
    chk("t6_zero_done", done, 1);
    chk("t6_zero_state", state, 3);
    tick();
    chk_idle("t6_zero_idle");
    load_val = 5; prescale = 3; start = 1;
    tick();
    load_val = 9;
    chk("t6_load", count, 5);
    tick();
    chk("t6_ign_start", count, 5);
    chk("t6_ign_run", running, 1);
    tick();
    tick();
    tick();
    start = 0;
    chk("t6_tick", count, 4);
    abort = 1;
    tick();
    abort = 0;
    chk_idle("t6_abort");
    load_val = 3; start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    chk_idle("t6_start_abort");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
